// File: rtl/rr_arb2_pkg.sv
// Shared definitions for the two-requester round-robin arbiter:
// FSM state encodings, default parameter values and a sizing helper.
package rr_arb2_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_HOLD = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  // Which requester received the most recent grant; used to break ties.
  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

  // Hold counter needs to represent 0..max_hold inclusive.
  function automatic int hold_width(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/rr_arb2_if.sv
// Requester/arbiter bundle: two request+data inputs and the shared output.
interface rr_arb2_if
  import rr_arb2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             req_a;
  logic             req_b;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             gnt_a;
  logic             gnt_b;
  logic             sel;
  logic [WIDTH-1:0] y;
  logic             y_valid;

  // Requester side drives requests and data, observes grants and output.
  modport master (
    output req_a, req_b, a, b,
    input  gnt_a, gnt_b, sel, y, y_valid
  );

  // Arbiter side.
  modport slave (
    input  req_a, req_b, a, b,
    output gnt_a, gnt_b, sel, y, y_valid
  );
endinterface

// File: rtl/rr_arb2_data_mux.sv
// WIDTH-bit 2:1 data select; sel=0 passes a, sel=1 passes b.
module data_mux #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  // Per-bit select, purely combinational.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign y[gi] = sel ? b[gi] : a[gi];
  end
endmodule

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a bounded hold time. A grant is
// kept while its owner requests, but is handed over after MAX_HOLD cycles
// if the other side is waiting. Grants appear one cycle after sampling.
module rr_arb2
  import rr_arb2_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD  // 1..255
) (
  input logic       clk,
  input logic       rst,
  rr_arb2_if.slave  bus
);
  localparam int            CW        = hold_width(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);

  state_t        state_reg, state_next;
  owner_t        last_reg, last_next;
  logic [CW-1:0] hold_reg, hold_next;
  logic          sel_reg, sel_next;
  logic          other_req;

  // State, hold counter, tie-break owner and mux select registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      last_reg  <= OWNER_B;  // A wins the first tie after reset
      hold_reg  <= '0;
      sel_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      hold_reg  <= hold_next;
      sel_reg   <= sel_next;
    end
  end

  // Next-state, hold counter and bookkeeping for the arbitration FSM.
  always_comb begin
    state_next = state_reg;
    other_req  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req_a && bus.req_b)
          state_next = (last_reg == OWNER_A) ? GRANT_B : GRANT_A;
        else if (bus.req_a)
          state_next = GRANT_A;
        else if (bus.req_b)
          state_next = GRANT_B;
      end
      GRANT_A: begin
        other_req = bus.req_b;
        if (!bus.req_a)
          state_next = bus.req_b ? GRANT_B : IDLE;
        else if (bus.req_b && hold_reg == HOLD_LAST)
          state_next = GRANT_B;  // preempt a long holder
      end
      GRANT_B: begin
        other_req = bus.req_a;
        if (!bus.req_b)
          state_next = bus.req_a ? GRANT_A : IDLE;
        else if (bus.req_a && hold_reg == HOLD_LAST)
          state_next = GRANT_A;
      end
      default: state_next = IDLE;
    endcase

    // Counter only measures how long the other side has been kept waiting.
    if (state_next != state_reg || !other_req)
      hold_next = '0;
    else if (hold_reg != HOLD_MAX)
      hold_next = hold_reg + CW'(1);
    else
      hold_next = hold_reg;

    last_next = last_reg;
    sel_next  = sel_reg;
    if (state_next == GRANT_A) begin
      sel_next = 1'b0;
      if (state_reg != GRANT_A) last_next = OWNER_A;
    end else if (state_next == GRANT_B) begin
      sel_next = 1'b1;
      if (state_reg != GRANT_B) last_next = OWNER_B;
    end
  end

  assign bus.gnt_a   = (state_reg == GRANT_A);
  assign bus.gnt_b   = (state_reg == GRANT_B);
  assign bus.sel     = sel_reg;
  assign bus.y_valid = (bus.gnt_a & bus.req_a) | (bus.gnt_b & bus.req_b);

  data_mux #(.WIDTH(WIDTH)) u_mux (
    .sel (sel_reg),
    .a   (bus.a),
    .b   (bus.b),
    .y   (bus.y)
  );
endmodule

// File: tb/tb_rr_arb2.sv
// Directed bench for rr_arb2: MAX_HOLD=4 instance for the main scenarios and
// a MAX_HOLD=1 instance for the alternate-every-cycle case.
module tb_rr_arb2;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic [7:0] a = 8'h11;
  logic [7:0] b = 8'h22;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  rr_arb2_if #(.WIDTH(8)) if0 ();
  rr_arb2_if #(.WIDTH(8)) if1 ();

  assign if0.req_a = req_a;
  assign if0.req_b = req_b;
  assign if0.a     = a;
  assign if0.b     = b;
  assign if1.req_a = req_a;
  assign if1.req_b = req_b;
  assign if1.a     = a;
  assign if1.b     = b;

  rr_arb2 #(.WIDTH(8), .MAX_HOLD(4)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  rr_arb2 #(.WIDTH(8), .MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  typedef struct {
    string      tag;
    bit         which;
    logic       ga;
    logic       gb;
    logic       sel;
    logic       vld;
    logic [7:0] y;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input bit which, input logic ga, input logic gb,
                      input logic s, input logic v);
    exp_t e;
    e.tag = tag; e.which = which; e.ga = ga; e.gb = gb; e.sel = s; e.vld = v;
    e.y = s ? b : a;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic ga, gb, s, v;
    logic [7:0] yy;
    if (sb.size() == 0) begin
      check("sb_empty", 8'd0, 8'd1);
      return;
    end
    e = sb.pop_front();
    if (e.which) begin
      ga = if1.gnt_a; gb = if1.gnt_b; s = if1.sel; v = if1.y_valid; yy = if1.y;
    end else begin
      ga = if0.gnt_a; gb = if0.gnt_b; s = if0.sel; v = if0.y_valid; yy = if0.y;
    end
    $display("[%0t] %s gnt_a=%b gnt_b=%b sel=%b y_valid=%b y=%h", $time, e.tag, ga, gb, s, v, yy);
    check({e.tag, ".gnt_a"}, {7'd0, ga}, {7'd0, e.ga});
    check({e.tag, ".gnt_b"}, {7'd0, gb}, {7'd0, e.gb});
    check({e.tag, ".sel"}, {7'd0, s}, {7'd0, e.sel});
    check({e.tag, ".y_valid"}, {7'd0, v}, {7'd0, e.vld});
    check({e.tag, ".y"}, yy, e.y);
  endtask

  // Check outputs right now (between edges).
  task automatic now_check(input string tag, input bit which, input logic ga, input logic gb,
                           input logic s, input logic v);
    push(tag, which, ga, gb, s, v);
    pop_check();
  endtask

  // Drive requests mid-cycle, expect the given outputs after the next edge.
  task automatic cyc(input string tag, input bit which, input logic ra, input logic rb,
                     input logic ga, input logic gb, input logic s, input logic v);
    @(negedge clk);
    req_a = ra;
    req_b = rb;
    push(tag, which, ga, gb, s, v);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset held with A requesting: no grant while rst is high.
    req_a = 1'b1;
    req_b = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    now_check("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    now_check("released_no_edge", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    push("first_grant_a", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    pop_check();
    cyc("a_drop_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Tie after reset goes to A; dropping A hands straight to B.
    req_a = 1'b0;
    do_reset();
    cyc("tie_a_first", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("handoff_b", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("b_keeps", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a B grant.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    now_check("async_rst_drop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    now_check("rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    now_check("rst_release_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    push("b_after_release", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    pop_check();

    // Idle keeps sel; then both held high -> 4 cycles each, A first (last=B).
    cyc("idle_sel_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      bit own_b;
      own_b = ((k / 4) % 2) == 1;
      cyc($sformatf("hold4_k%0d", k), 1'b0, 1'b1, 1'b1, !own_b, own_b, own_b, 1'b1);
    end

    // B pulse of two cycles: counter clears, A keeps the grant.
    cyc("to_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("a_alone", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("b_pulse1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("b_pulse2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++)
      cyc($sformatf("a_keeps%0d", k), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    // Fresh full wait after the clear: preempted only on the fourth cycle.
    cyc("b_wait1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("b_wait2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("b_wait3", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("b_preempts", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // A owns, drops for one cycle with B idle: invalid cycle, IDLE, regrant.
    cyc("b_drops_to_a", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    req_a = 1'b0;
    #1;
    now_check("a_dropped_invalid", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    now_check("a_drop_idle2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("a_returns", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // MAX_HOLD=1: both held high alternates every cycle.
    req_a = 1'b0;
    req_b = 1'b0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      bit own_b;
      own_b = (k % 2) == 1;
      cyc($sformatf("hold1_k%0d", k), 1'b1, 1'b1, 1'b1, !own_b, own_b, own_b, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
